// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port RAM between the decoder
// writer and the display reader. Grants are combinational. RAM controls are
// registered one cycle after the grant. Read data returns 1+RD_LATENCY cycles
// after rd_gnt.
// The display wins ties. An owner keeps the port for at most MAX_BURST
// consecutive grants while the other side is waiting. A requester holds its
// req and payload until it sees its gnt.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   wr_req/wr_addr/wr_data    decoder write request; wr_gnt accepts it
//   rd_req/rd_addr            display read request; rd_gnt accepts it
//   rd_data/rd_valid          returned pixel, one rd_valid pulse per read, in order
//   mem_en/mem_we/mem_addr/mem_wdata   registered RAM controls
//   mem_rdata                 RAM read data, RD_LATENCY cycles after mem_en
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_OWN = 2'd1,
    WR_OWN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             gnt_rd;
  logic             gnt_wr;

  // Read tag pipeline. Stage 0 lines up with mem_en. The last stage lines up
  // with the cycle in which the RAM presents the read data.
  logic [RD_LATENCY:0] rd_pipe;
  logic [DATA_W-1:0]   rd_hold;

  // ---------------------------------------------------------------------------
  // Owner state and burst counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    gnt_rd    = 1'b0;
    gnt_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          gnt_rd    = 1'b1;
          state_nxt = RD_OWN;
          cnt_nxt   = CNT_ONE;
        end else if (wr_req) begin
          gnt_wr    = 1'b1;
          state_nxt = WR_OWN;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      RD_OWN: begin
        // The owner keeps the port unless the other side waits and the burst is spent.
        if (rd_req && (!wr_req || (burst_cnt < CNT_MAX))) begin
          gnt_rd = 1'b1;
          if (burst_cnt < CNT_MAX) begin
            cnt_nxt = burst_cnt + CNT_ONE;
          end
        end else if (wr_req) begin
          gnt_wr    = 1'b1;
          state_nxt = WR_OWN;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      WR_OWN: begin
        if (wr_req && (!rd_req || (burst_cnt < CNT_MAX))) begin
          gnt_wr = 1'b1;
          if (burst_cnt < CNT_MAX) begin
            cnt_nxt = burst_cnt + CNT_ONE;
          end
        end else if (rd_req) begin
          gnt_rd    = 1'b1;
          state_nxt = RD_OWN;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grants are forced low while reset is held. The state register is already
  // IDLE then, but incoming requests would otherwise still produce a grant.
  assign rd_gnt = reset_n & gnt_rd;
  assign wr_gnt = reset_n & gnt_wr;

  // ---------------------------------------------------------------------------
  // Registered RAM access
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= rd_gnt | wr_gnt;
      mem_we <= wr_gnt;
      if (wr_gnt) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (rd_gnt) begin
        mem_addr  <= rd_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LATENCY-1:0], rd_gnt};
    end
  end

  assign rd_valid = rd_pipe[RD_LATENCY];

  // The RAM data is only guaranteed during the rd_valid cycle. It is passed
  // through in that cycle and latched, so rd_data keeps its value until the
  // next read returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_hold <= '0;
    end else if (rd_valid) begin
      rd_hold <= mem_rdata;
    end
  end

  assign rd_data = rd_valid ? mem_rdata : rd_hold;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(rd_gnt && wr_gnt));
  a_rd_gnt_req: assert property (@(posedge clk) disable iff (!reset_n)
    rd_gnt |-> rd_req);
  a_wr_gnt_req: assert property (@(posedge clk) disable iff (!reset_n)
    wr_gnt |-> wr_req);
  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
    burst_cnt <= CNT_MAX);

endmodule
